// File: rtl/ldst_sequencer.sv
// ldst_sequencer: T0..T7 control-step sequencer for ld/ldi/st with a mem_ack
// handshake, a memory-timeout watchdog and a sticky fault state.
module ldst_sequencer #(
  parameter int unsigned      OPC_W   = 5,
  parameter logic [OPC_W-1:0] OP_LD   = 5'b00000,
  parameter logic [OPC_W-1:0] OP_LDI  = 5'b00001,
  parameter logic [OPC_W-1:0] OP_ST   = 5'b00010,
  parameter int unsigned      MEM_TMO = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [OPC_W-1:0] ir_opcode,
  input  logic             mem_ack,
  output logic             PCout,
  output logic             Zlowout,
  output logic             MDRout,
  output logic             BAout,
  output logic             Cout,
  output logic             Rout,
  output logic             MARin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             Rin,
  output logic             IncPC,
  output logic             alu_add,
  output logic             Gra,
  output logic             Grb,
  output logic             mem_read,
  output logic             mem_write,
  output logic             busy,
  output logic             instr_done,
  output logic             fault,
  output logic [3:0]       state
);

  localparam int unsigned   CNT_W    = $clog2(MEM_TMO + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TMO - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_FAULT = 4'd15
  } state_t;

  typedef struct packed {
    logic pcOut, zlowOut, mdrOut, baOut, cOut, rOut;
    logic marIn, pcIn, mdrIn, irIn, yIn, zIn, rIn;
    logic incPc, aluAdd, gra, grb, memRead, memWrite;
  } ctrl_t;

  state_t           r_state;
  ctrl_t            r_ctrl;
  logic             r_busy;
  logic             r_fault;
  logic             r_doneBase;
  logic [OPC_W-1:0] r_op;
  logic [CNT_W-1:0] r_cnt;

  state_t w_stateNext;
  state_t w_endNext;
  ctrl_t  w_ctrlNext;
  logic   w_req;
  logic   w_tmo;
  logic   w_opLegal;

  // Strobes for a given step; the op only matters from T5 on, after it is latched.
  function automatic ctrl_t decode(input state_t s, input logic [OPC_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_T0: begin c.pcOut = 1'b1; c.marIn = 1'b1; c.incPc = 1'b1; c.zIn = 1'b1; end
      S_T1: begin c.zlowOut = 1'b1; c.pcIn = 1'b1; c.memRead = 1'b1; c.mdrIn = 1'b1; end
      S_T2: begin c.mdrOut = 1'b1; c.irIn = 1'b1; end
      S_T3: begin c.grb = 1'b1; c.baOut = 1'b1; c.yIn = 1'b1; end
      S_T4: begin c.cOut = 1'b1; c.aluAdd = 1'b1; c.zIn = 1'b1; end
      S_T5: begin
        c.zlowOut = 1'b1;
        if (op == OP_LDI) begin c.gra = 1'b1; c.rIn = 1'b1; end
        else c.marIn = 1'b1;
      end
      S_T6: begin
        c.mdrIn = 1'b1;
        if (op == OP_ST) begin c.gra = 1'b1; c.rOut = 1'b1; end
        else c.memRead = 1'b1;
      end
      S_T7: begin
        if (op == OP_ST) c.memWrite = 1'b1;
        else begin c.mdrOut = 1'b1; c.gra = 1'b1; c.rIn = 1'b1; end
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    w_req       = r_ctrl.memRead | r_ctrl.memWrite;
    w_tmo       = w_req && !mem_ack && (r_cnt == TMO_LAST);
    w_opLegal   = (ir_opcode == OP_LD) || (ir_opcode == OP_LDI) || (ir_opcode == OP_ST);
    w_endNext   = run ? S_T0 : S_IDLE;
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (run) w_stateNext = S_T0;
      S_T0:    w_stateNext = S_T1;
      S_T1: begin
        if (mem_ack)    w_stateNext = S_T2;
        else if (w_tmo) w_stateNext = S_FAULT;
      end
      S_T2:    w_stateNext = S_T3;
      S_T3:    w_stateNext = w_opLegal ? S_T4 : S_FAULT;
      S_T4:    w_stateNext = S_T5;
      S_T5:    w_stateNext = (r_op == OP_LDI) ? w_endNext : S_T6;
      S_T6: begin
        if (r_op == OP_ST || mem_ack) w_stateNext = S_T7;
        else if (w_tmo)               w_stateNext = S_FAULT;
      end
      S_T7: begin
        if (r_op != OP_ST || mem_ack) w_stateNext = w_endNext;
        else if (w_tmo)               w_stateNext = S_FAULT;
      end
      S_FAULT: w_stateNext = S_FAULT;
      default: w_stateNext = S_IDLE;
    endcase
    w_ctrlNext = decode(w_stateNext, r_op);
  end

  // Outputs are registered from the next state, so they always match r_state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= S_IDLE;
      r_ctrl     <= '0;
      r_busy     <= 1'b0;
      r_fault    <= 1'b0;
      r_doneBase <= 1'b0;
      r_op       <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_ctrl     <= w_ctrlNext;
      r_busy     <= (w_stateNext != S_IDLE) && (w_stateNext != S_FAULT);
      r_fault    <= (w_stateNext == S_FAULT);
      r_doneBase <= ((w_stateNext == S_T5) && (r_op == OP_LDI)) ||
                    ((w_stateNext == S_T7) && (r_op == OP_LD));
      if (r_state == S_T3) r_op <= ir_opcode;
      if (w_stateNext != r_state)  r_cnt <= '0;
      else if (w_req && !mem_ack)  r_cnt <= r_cnt + 1'b1;
    end
  end

  assign PCout     = r_ctrl.pcOut;
  assign Zlowout   = r_ctrl.zlowOut;
  assign MDRout    = r_ctrl.mdrOut;
  assign BAout     = r_ctrl.baOut;
  assign Cout      = r_ctrl.cOut;
  assign Rout      = r_ctrl.rOut;
  assign MARin     = r_ctrl.marIn;
  assign PCin      = r_ctrl.pcIn;
  assign MDRin     = r_ctrl.mdrIn;
  assign IRin      = r_ctrl.irIn;
  assign Yin       = r_ctrl.yIn;
  assign Zin       = r_ctrl.zIn;
  assign Rin       = r_ctrl.rIn;
  assign IncPC     = r_ctrl.incPc;
  assign alu_add   = r_ctrl.aluAdd;
  assign Gra       = r_ctrl.gra;
  assign Grb       = r_ctrl.grb;
  assign mem_read  = r_ctrl.memRead;
  assign mem_write = r_ctrl.memWrite;
  assign busy      = r_busy;
  assign fault     = r_fault;
  assign state     = r_state;

  // A store completes in the very cycle its write is acknowledged.
  assign instr_done = r_doneBase || ((r_state == S_T7) && (r_op == OP_ST) && mem_ack);

endmodule

// File: tb/tb_ldst_sequencer.sv
// tb_ldst_sequencer: directed and randomized checks of ldst_sequencer against
// a step-level behavioural model of the ld/ldi/st control sequence.
module tb_ldst_sequencer;

  localparam int MEM_TMO = 16;
  localparam logic [4:0] LD  = 5'b00000;
  localparam logic [4:0] LDI = 5'b00001;
  localparam logic [4:0] ST  = 5'b00010;

  localparam int B_PCOUT = 18, B_ZLOW = 17, B_MDROUT = 16, B_BAOUT = 15, B_COUT = 14;
  localparam int B_ROUT = 13, B_MARIN = 12, B_PCIN = 11, B_MDRIN = 10, B_IRIN = 9;
  localparam int B_YIN = 8, B_ZIN = 7, B_RIN = 6, B_INCPC = 5, B_ADD = 4;
  localparam int B_GRA = 3, B_GRB = 2, B_MRD = 1, B_MWR = 0;

  logic clk;
  logic clr;
  logic run;
  logic [4:0] ir_opcode;
  logic mem_ack;
  logic PCout, Zlowout, MDRout, BAout, Cout, Rout;
  logic MARin, PCin, MDRin, IRin, Yin, Zin, Rin;
  logic IncPC, alu_add, Gra, Grb, mem_read, mem_write;
  logic busy, instr_done, fault;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;

  // Model: current step (0 idle, 1+k for Tk, 15 fault), latched op, cycles waited on memory.
  logic [3:0] mState;
  logic [4:0] mOp;
  int         mWait;

  ldst_sequencer #(
    .OPC_W(5), .OP_LD(LD), .OP_LDI(LDI), .OP_ST(ST), .MEM_TMO(MEM_TMO)
  ) dut (
    .clk(clk), .clr(clr), .run(run), .ir_opcode(ir_opcode), .mem_ack(mem_ack),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .BAout(BAout), .Cout(Cout),
    .Rout(Rout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .Rin(Rin), .IncPC(IncPC), .alu_add(alu_add), .Gra(Gra), .Grb(Grb),
    .mem_read(mem_read), .mem_write(mem_write), .busy(busy), .instr_done(instr_done),
    .fault(fault), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] strobeVec();
    return {PCout, Zlowout, MDRout, BAout, Cout, Rout, MARin, PCin, MDRin, IRin,
            Yin, Zin, Rin, IncPC, alu_add, Gra, Grb, mem_read, mem_write};
  endfunction

  // Strobe table of the instruction class, per step and op.
  function automatic logic [18:0] expStrobes(input logic [3:0] st, input logic [4:0] op);
    logic [18:0] m;
    m = '0;
    case (st)
      4'd1: begin m[B_PCOUT] = 1; m[B_MARIN] = 1; m[B_INCPC] = 1; m[B_ZIN] = 1; end
      4'd2: begin m[B_ZLOW] = 1; m[B_PCIN] = 1; m[B_MRD] = 1; m[B_MDRIN] = 1; end
      4'd3: begin m[B_MDROUT] = 1; m[B_IRIN] = 1; end
      4'd4: begin m[B_GRB] = 1; m[B_BAOUT] = 1; m[B_YIN] = 1; end
      4'd5: begin m[B_COUT] = 1; m[B_ADD] = 1; m[B_ZIN] = 1; end
      4'd6: if (op == LDI) begin m[B_ZLOW] = 1; m[B_GRA] = 1; m[B_RIN] = 1; end
            else begin m[B_ZLOW] = 1; m[B_MARIN] = 1; end
      4'd7: if (op == LD) begin m[B_MRD] = 1; m[B_MDRIN] = 1; end
            else begin m[B_GRA] = 1; m[B_ROUT] = 1; m[B_MDRIN] = 1; end
      4'd8: if (op == LD) begin m[B_MDROUT] = 1; m[B_GRA] = 1; m[B_RIN] = 1; end
            else m[B_MWR] = 1;
      default: ;
    endcase
    return m;
  endfunction

  // Step-level reference: advance by the instruction-class rules each clock.
  always @(posedge clk or negedge clr) begin
    logic [3:0] ns;
    int         nw;
    logic [4:0] no;
    logic       isMem, finished;
    if (!clr) begin
      mState <= 4'd0;
      mWait  <= 0;
      mOp    <= 5'd0;
    end else begin
      ns = mState;
      nw = mWait;
      no = mOp;
      isMem    = (mState == 4'd2) || (mState == 4'd7 && mOp == LD) || (mState == 4'd8 && mOp == ST);
      finished = (mState == 4'd6 && mOp == LDI) || (mState == 4'd8);
      if (mState == 4'd0) ns = run ? 4'd1 : 4'd0;
      else if (mState == 4'd15) ns = 4'd15;
      else if (isMem && !mem_ack) begin
        nw = mWait + 1;
        if (nw >= MEM_TMO) begin ns = 4'd15; nw = 0; end
      end else begin
        nw = 0;
        if (finished) ns = run ? 4'd1 : 4'd0;
        else if (mState == 4'd4) begin
          no = ir_opcode;
          ns = (ir_opcode == LD || ir_opcode == LDI || ir_opcode == ST) ? 4'd5 : 4'd15;
        end else ns = mState + 4'd1;
      end
      mState <= ns;
      mWait  <= nw;
      mOp    <= no;
    end
  end

  task automatic checkOutput();
    logic [18:0] expS;
    logic        expDone, expBusy, expFault;
    expS     = expStrobes(mState, mOp);
    expBusy  = (mState != 4'd0) && (mState != 4'd15);
    expFault = (mState == 4'd15);
    expDone  = (mState == 4'd6 && mOp == LDI) || (mState == 4'd8 && mOp == LD) ||
               (mState == 4'd8 && mOp == ST && mem_ack);
    vectors++;
    if (state !== mState || strobeVec() !== expS || busy !== expBusy ||
        fault !== expFault || instr_done !== expDone) begin
      miscompares++;
      $display("[TB] FAIL cycle t=%0t: got state=%0d strobes=%05h busy=%b fault=%b done=%b, want state=%0d strobes=%05h busy=%b fault=%b done=%b",
               $time, state, strobeVec(), busy, fault, instr_done,
               mState, expS, expBusy, expFault, expDone);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ackDelay < 0: random ack; otherwise ack once that many cycles have been waited.
  task automatic applyStimulus(input logic r, input int ackDelay, input logic [4:0] op);
    @(negedge clk);
    run       = r;
    ir_opcode = op;
    if (ackDelay < 0) mem_ack = ($urandom_range(0, 9) < 6);
    else              mem_ack = (mWait >= ackDelay);
    #1 checkOutput();
  endtask

  task automatic pulseReset();
    #2 clr = 1'b0;
    #1 checkOutput();
    checkValue("clr_async_state", int'(state), 0);
    checkValue("clr_async_strobes", int'(strobeVec()), 0);
    checkValue("clr_async_fault", int'(fault), 0);
    @(negedge clk);
    clr = 1'b1;
  endtask

  initial begin
    int nBusy, nDone, nA, nB, nBoth, faultAge, found, pick;
    logic [4:0] op;
    clr = 1'b0; run = 1'b0; mem_ack = 1'b0; ir_opcode = 5'd0;
    #12;
    checkOutput();
    checkValue("reset_state", int'(state), 0);
    checkValue("reset_busy", int'(busy), 0);
    @(negedge clk);
    clr = 1'b1;

    // ldi, zero-wait memory, one-cycle run pulse
    applyStimulus(1'b1, 0, LDI);
    nBusy = 0; nDone = 0; nA = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 0, LDI);
      nBusy += int'(busy); nDone += int'(instr_done); nA += int'(Gra && Rin);
    end
    checkValue("ldi_cycles", nBusy, 6);
    checkValue("ldi_done_pulses", nDone, 1);
    checkValue("ldi_gra_rin_cycles", nA, 1);
    checkValue("ldi_end_idle", int'(state), 0);

    // ld, ack after three waited cycles in T1 and in T6
    applyStimulus(1'b1, 3, LD);
    nBusy = 0; nA = 0; nB = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 3, LD);
      nBusy += int'(busy); nA += int'(mem_read); nB += int'(mem_read && MDRin);
    end
    checkValue("ld_cycles", nBusy, 14);
    checkValue("ld_read_cycles", nA, 8);
    checkValue("ld_mdrin_during_read", nB, 8);

    // st, run held high: back-to-back instructions
    applyStimulus(1'b1, 2, ST);
    nDone = 0; nA = 0; nBoth = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 2, ST);
      nDone += int'(instr_done); nA += int'(Rout && MDRin); nBoth += int'(mem_read && mem_write);
    end
    checkValue("st_done_pulses", nDone, 1);
    checkValue("st_rout_mdrin", nA, 1);
    applyStimulus(1'b1, 2, ST);
    checkValue("st_next_T0", int'(state), 1);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, 2, ST);
      nBoth += int'(mem_read && mem_write);
    end
    checkValue("st_read_with_write", nBoth, 0);
    checkValue("st_end_idle", int'(state), 0);

    // illegal opcode at T3
    applyStimulus(1'b1, 0, 5'b00011);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 5'b00011);
    applyStimulus(1'b0, 0, 5'b00011);
    checkValue("illegal_state", int'(state), 15);
    checkValue("illegal_fault", int'(fault), 1);
    checkValue("illegal_busy", int'(busy), 0);
    checkValue("illegal_strobes", int'(strobeVec()), 0);
    applyStimulus(1'b1, 0, LD);
    checkValue("fault_sticky", int'(state), 15);
    pulseReset();

    // watchdog: ack stuck low in T1
    applyStimulus(1'b1, 1000, LD);
    nA = 0;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b0, 1000, LD);
      nA += int'(state == 4'd2);
    end
    checkValue("tmo_T1_cycles", nA, 16);
    checkValue("tmo_state", int'(state), 15);
    pulseReset();

    // async clear in the middle of a T6 read wait
    applyStimulus(1'b1, 5, LD);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      applyStimulus(1'b0, 5, LD);
      if (mState == 4'd7 && mWait == 2) found = 1;
    end
    checkValue("t6_wait_reached", found, 1);
    checkValue("t6_read_before_clr", int'(mem_read), 1);
    pulseReset();

    // randomized traffic
    faultAge = 0;
    for (int c = 0; c < 3000; c++) begin
      pick = $urandom_range(0, 19);
      if (pick < 6)       op = LD;
      else if (pick < 12) op = LDI;
      else if (pick < 18) op = ST;
      else                op = 5'($urandom_range(0, 31));
      applyStimulus($urandom_range(0, 99) < 80, -1, op);
      if (mState == 4'd15) faultAge++; else faultAge = 0;
      if (faultAge >= 3 || $urandom_range(0, 199) == 0) begin
        pulseReset();
        faultAge = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
